// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default register-file widths and the
// writeback queue entry layout.
package mips_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order circular FIFO of pending register writes. Every live entry is also
// exposed oldest-first so the owner can search for the newest match.
module wb_queue
    import mips_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_entry_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  T              i_data,
    input  logic          i_pop,
    output T              o_head,
    output logic [CW-1:0] o_count,
    output T              o_entries [DEPTH],
    output logic [DEPTH-1:0] o_live
);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage is not reset; only the pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Slot i is the i-th oldest entry; pointer arithmetic wraps at DEPTH.
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        assign o_entries[i] = r_mem[r_rd_ptr + PW'(i)];
        assign o_live[i]    = (CW'(i) < r_count);
    end

endmodule

// File: rtl/wb_writeback_port.sv
// Writeback driver for the register-file write port: queues MEM results,
// retires one per cycle, forwards pending data and arbitrates a debug writer.
module wb_writeback_port
    import mips_pkg::*;
#(
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              in_mem_to_reg,
    input  logic              freeze,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_dest,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [15:0]       wb_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             w_in_entry;
    entry_t             w_head;
    entry_t             w_entries [DEPTH];
    logic [DEPTH-1:0]   w_live;
    logic [CW-1:0]      w_count;
    logic               w_push;
    logic               w_pop;
    logic               w_head_drv;
    logic               w_dbg_drv;

    logic [ADDR_W-1:0]  r_last_reg;
    logic [DATA_W-1:0]  r_last_data;
    logic [15:0]        r_wb_count;

    assign w_in_entry.we   = in_we;
    assign w_in_entry.dest = in_dest;
    assign w_in_entry.data = in_mem_to_reg ? in_mem_data : in_alu_data;

    assign in_ready  = reset_n & (w_count < CW'(DEPTH));
    assign dbg_ready = reset_n & (freeze | (w_count == '0));

    assign w_push     = in_valid & in_ready;
    assign w_head_drv = (w_count != '0) & ~freeze;
    assign w_pop      = w_head_drv;
    assign w_dbg_drv  = dbg_valid & dbg_ready & ~w_head_drv;

    wb_queue #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_data    (w_in_entry),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_entries (w_entries),
        .o_live    (w_live)
    );

    // An idle port keeps presenting the last address/data it carried.
    always_comb begin
        reg_write      = 1'b0;
        write_register = r_last_reg;
        write_data     = r_last_data;
        if (w_head_drv) begin
            reg_write      = w_head.we & (w_head.dest != ZERO);
            write_register = w_head.dest;
            write_data     = w_head.data;
        end else if (w_dbg_drv) begin
            reg_write      = (dbg_dest != ZERO);
            write_register = dbg_dest;
            write_data     = dbg_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_reg  <= '0;
            r_last_data <= '0;
            r_wb_count  <= '0;
        end else begin
            if (w_head_drv | w_dbg_drv) begin
                r_last_reg  <= write_register;
                r_last_data <= write_data;
            end
            if (reg_write)
                r_wb_count <= r_wb_count + 16'd1;
        end
    end

    assign wb_count = r_wb_count;

    // Slots are scanned oldest to newest so the newest match wins.
    always_comb begin
        fwd_data1 = rf_data1;
        fwd_data2 = rf_data2;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i] && w_entries[i].we && w_entries[i].dest == rd_addr1)
                fwd_data1 = w_entries[i].data;
            if (w_live[i] && w_entries[i].we && w_entries[i].dest == rd_addr2)
                fwd_data2 = w_entries[i].data;
        end
        if (rd_addr1 == ZERO)
            fwd_data1 = '0;
        if (rd_addr2 == ZERO)
            fwd_data2 = '0;
    end

endmodule

// File: tb/tb_wb_writeback_port.sv
// Directed and randomized bench for wb_writeback_port against a queue-level
// model of pending writes, with a simple register file behind the port.
module tb_wb_writeback_port;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, in_we, in_mem_to_reg;
    logic [AW-1:0] in_dest;
    logic [DW-1:0] in_alu_data, in_mem_data;
    logic          freeze, dbg_valid, dbg_ready;
    logic [AW-1:0] dbg_dest;
    logic [DW-1:0] dbg_data;
    logic          reg_write;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rf_data1, rf_data2, fwd_data1, fwd_data2;
    logic [15:0]   wb_count;

    always #5 clk = ~clk;

    wb_writeback_port #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_dest(in_dest),
        .in_alu_data(in_alu_data), .in_mem_data(in_mem_data), .in_mem_to_reg(in_mem_to_reg),
        .freeze(freeze), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
        .dbg_dest(dbg_dest), .dbg_data(dbg_data),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .wb_count(wb_count)
    );

    // Register file fed by the DUT port
    logic [DW-1:0] rf [32] = '{default: '0};
    always @(posedge clk) if (reg_write) rf[write_register] <= write_data;
    assign rf_data1 = rf[rd_addr1];
    assign rf_data2 = rf[rd_addr2];

    typedef struct {
        logic          we;
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } ment_t;

    ment_t         m_q[$];
    logic [15:0]   m_cnt;
    logic [AW-1:0] m_last_reg;
    logic [DW-1:0] m_last_data;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_cnt       = '0;
        m_last_reg  = '0;
        m_last_data = '0;
    endtask

    function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] a, input logic [DW-1:0] rfv);
        logic [DW-1:0] r;
        r = rfv;
        if (a == 0) return '0;
        foreach (m_q[i]) if (m_q[i].we && m_q[i].dest == a) r = m_q[i].data;
        return r;
    endfunction

    task automatic put(input logic v, input logic we, input logic [AW-1:0] d,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic m2r);
        in_valid = v; in_we = we; in_dest = d;
        in_alu_data = alu; in_mem_data = mem; in_mem_to_reg = m2r;
    endtask

    task automatic dbg(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
        dbg_valid = v; dbg_dest = d; dbg_data = x;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic step();
        logic head, dbgw, e_rw, e_ir, e_dr;
        logic [AW-1:0] e_wr;
        logic [DW-1:0] e_wd;
        ment_t ne;
        #1;
        e_ir = (m_q.size() < DEPTH);
        e_dr = freeze || (m_q.size() == 0);
        head = (m_q.size() != 0) && !freeze;
        dbgw = !head && dbg_valid && e_dr;
        if (head) begin
            e_rw = m_q[0].we && (m_q[0].dest != 0); e_wr = m_q[0].dest; e_wd = m_q[0].data;
        end else if (dbgw) begin
            e_rw = (dbg_dest != 0); e_wr = dbg_dest; e_wd = dbg_data;
        end else begin
            e_rw = 1'b0; e_wr = m_last_reg; e_wd = m_last_data;
        end
        chk("in_ready", in_ready, e_ir);
        chk("dbg_ready", dbg_ready, e_dr);
        chk("reg_write", reg_write, e_rw);
        chk("write_register", write_register, e_wr);
        chk("write_data", write_data, e_wd);
        chk("fwd_data1", fwd_data1, m_fwd(rd_addr1, rf_data1));
        chk("fwd_data2", fwd_data2, m_fwd(rd_addr2, rf_data2));
        chk("wb_count", wb_count, m_cnt);
        ne.we = in_we; ne.dest = in_dest;
        ne.data = in_mem_to_reg ? in_mem_data : in_alu_data;
        @(posedge clk);
        if (e_rw) m_cnt++;
        if (head || dbgw) begin m_last_reg = e_wr; m_last_data = e_wd; end
        if (head) void'(m_q.pop_front());
        if (in_valid && e_ir) m_q.push_back(ne);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1;
        put(0, 0, 0, 0, 0, 0);
        dbg(0, 0, 0);
        freeze = 0; rd_addr1 = 0; rd_addr2 = 0;
        m_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_dbg_ready", dbg_ready, 1'b0);
        chk("rst_write_register", write_register, '0);
        chk("rst_write_data", write_data, '0);
        chk("rst_wb_count", wb_count, '0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back writes, middle one through the load-data path
        rd_addr1 = 1; rd_addr2 = 2;
        put(1, 1, 1, 5, 0, 0);   step();
        put(1, 1, 2, 99, 6, 1);  step();
        put(1, 1, 1, 8, 0, 0);   step();
        put(0, 0, 0, 0, 0, 0);   step(); step();
        chk("seq_rf1", rf[1], 32'd8);
        chk("seq_rf2", rf[2], 32'd6);
        chk("seq_count", wb_count, 16'd3);

        // Writes to $zero retire silently
        rd_addr1 = 0;
        put(1, 1, 0, 8, 0, 0);   step();
        put(0, 0, 0, 0, 0, 0);   step(); step();
        chk("zero_count", wb_count, 16'd3);
        chk("zero_fwd", fwd_data1, '0);

        // Forwarding picks the newest pending write to the same register
        dbg(1, 3, 32'h1);        step();
        dbg(0, 0, 0);
        freeze = 1; rd_addr1 = 3;
        put(1, 1, 3, 32'hA, 0, 0); step();
        put(1, 1, 3, 32'hB, 0, 0); step();
        put(0, 0, 0, 0, 0, 0);
        #1;
        chk("fwd_rf_stale", rf_data1, 32'h1);
        chk("fwd_newest", fwd_data1, 32'hB);
        freeze = 0;
        step(); step(); step();
        chk("fwd_after_commit", fwd_data1, 32'hB);
        chk("fwd_rf3", rf[3], 32'hB);

        // Backpressure under freeze, debug port still granted
        freeze = 1;
        put(1, 1, 5, 32'h50, 0, 0); step();
        put(1, 1, 6, 32'h60, 0, 0); step();
        put(1, 1, 7, 32'h70, 0, 0);
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        step();
        put(0, 0, 0, 0, 0, 0);
        dbg(1, 4, 32'h55);       step();
        dbg(0, 0, 0);
        chk("bp_dbg_rf4", rf[4], 32'h55);
        freeze = 0;
        step(); step(); step();
        chk("bp_rf5", rf[5], 32'h50);
        chk("bp_rf6", rf[6], 32'h60);
        chk("bp_rf7_dropped", rf[7], '0);

        // Debug waits for the queue to drain
        freeze = 1;
        put(1, 1, 8, 32'h80, 0, 0); step();
        put(1, 1, 9, 32'h90, 0, 0); step();
        put(0, 0, 0, 0, 0, 0);
        freeze = 0;
        dbg(1, 9, 32'h99);
        #1;
        chk("arb_dbg_blocked", dbg_ready, 1'b0);
        step(); step();
        #1;
        chk("arb_dbg_granted", dbg_ready, 1'b1);
        step();
        dbg(0, 0, 0);
        chk("arb_rf9", rf[9], 32'h99);
        chk("arb_rf8", rf[8], 32'h80);
        step();

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 300; n++) begin
            freeze = ($urandom_range(3) == 0);
            put(1'($urandom_range(1)), ($urandom_range(3) != 0), AW'($urandom_range(7)),
                $urandom, $urandom, 1'($urandom_range(1)));
            dbg(($urandom_range(3) == 0), AW'($urandom_range(7)), $urandom);
            rd_addr1 = AW'($urandom_range(7));
            rd_addr2 = AW'($urandom_range(7));
            step();
        end
        freeze = 0;
        put(0, 0, 0, 0, 0, 0);
        dbg(0, 0, 0);
        step(); step(); step();

        // Reset with entries pending discards them
        rd_addr1 = 10; rd_addr2 = 11;
        freeze = 1;
        put(1, 1, 10, 32'hAA, 0, 0); step();
        put(1, 1, 11, 32'hBB, 0, 0); step();
        put(0, 0, 0, 0, 0, 0);
        freeze = 0;
        #1 reset_n = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_reg_write", reg_write, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_dbg_ready", dbg_ready, 1'b0);
        chk("mid_rst_wb_count", wb_count, '0);
        @(negedge clk);
        reset_n = 1'b1;
        step(); step();
        chk("mid_rst_rf10", rf[10], '0);
        chk("mid_rst_rf11", rf[11], '0);
        chk("mid_rst_count_after", wb_count, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_writeback_port.md
Name: wb_writeback_port

Overview:
Writeback-side driver for the MIPS register file write port (clk, reg_write, write_register, write_data). It accepts completed results from the MEM stage over a valid/ready handshake and buffers them in a small in-order queue. It retires one write per cycle into the register file and forwards pending results to the decode-stage read ports. A debug/loader write port shares the register-file write port under fixed priority.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
DEPTH, 2, pending-write queue entries (power of 2, >=2)

Ports:
clk  in  1  clock; the register file commits on posedge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  MEM-stage result valid
in_ready  out  1  queue can accept
in_we  in  1  instruction writes a register
in_dest  in  ADDR_W  destination register
in_alu_data  in  DATA_W  ALU result
in_mem_data  in  DATA_W  load data
in_mem_to_reg  in  1  1 selects in_mem_data
freeze  in  1  hold pipeline retirement and grant the debug port
dbg_valid  in  1  debug write request
dbg_ready  out  1  debug write granted this cycle
dbg_dest  in  ADDR_W  debug destination
dbg_data  in  DATA_W  debug data
reg_write  out  1  to register file
write_register  out  ADDR_W  to register file
write_data  out  DATA_W  to register file
rd_addr1, rd_addr2  in  ADDR_W  decode read addresses (mirror read_register1/2)
rf_data1, rf_data2  in  DATA_W  register file read_data1/2
fwd_data1, fwd_data2  out  DATA_W  forwarded read data
wb_count  out  16  retired register writes, wraps

Behaviour:
- Reset (async, reset_n low): queue emptied, wb_count=0, in_ready=0, reg_write=0, write_register=0, write_data=0, dbg_ready=0. Pending entries are discarded, not written.
- Accept on posedge when in_valid&in_ready. The entry stores {we, dest, data}, with data=in_mem_to_reg?in_mem_data:in_alu_data.
- in_ready = reset_n & (count<DEPTH), based on the registered count. Pop and push can occur on the same edge.
- Head drive: when the queue is non-empty and freeze=0, the head entry owns the port.
  - reg_write = head.we & (head.dest!=0).
  - write_register = head.dest, write_data = head.data.
  - The head pops on the next posedge.
- Latency: an entry accepted at edge k into an empty queue appears on the port during cycle k..k+1 and commits at edge k+1.
- Throughput: 1 write/cycle.
- Debug grant:
  - dbg_ready = reset_n & (freeze | count==0).
  - When dbg_valid&dbg_ready, the port carries dbg_dest/dbg_data, with reg_write = (dbg_dest!=0).
  - The write commits at the same edge; the handshake is single-cycle.
- Idle port: reg_write=0; write_register and write_data hold their last driven values.
- Register 0: writes to $zero are popped/acked but never assert reg_write and are not counted.
- wb_count increments by 1 on every edge where reg_write=1, from either source, and wraps at 0xFFFF->0.
- freeze mid-stream: the head is held and stays unretired. The queue fills, and in_ready drops at count==DEPTH. Release resumes in order, one entry per cycle.
- Forwarding:
  - fwd_dataN = 0 if rd_addrN==0.
  - Otherwise it takes the data of the newest queued entry with we=1 and dest==rd_addrN.
  - Otherwise it is rf_dataN.
  - Forwarding is combinational.
  - The head entry forwards during its commit cycle.
- Simultaneous accept into an empty queue with a debug request: the debug request is granted this cycle (count==0). The pipeline entry drives the port next cycle.

Decomposition:
- Shared package mips_pkg holds the ADDR_W/DATA_W defaults, the REG_ZERO=0 constant, and the wb_entry_t struct {we, dest, data}.
- Natural sub-module: wb_queue, a DEPTH-entry circular FIFO with wrap-around pointers, count, and parallel entry visibility for the forwarding search.
- Port mux, forwarding logic and counter live in the top level.

Test Plan:
- Sequential writes: in {we=1,dest=1,alu=5}, then {dest=2,alu=6}, then {dest=1,alu=8} on consecutive cycles -> reg_write pulses three cycles. Final rf[1]=8, rf[2]=6, wb_count=3.
- $zero: in {we=1,dest=0,alu=8} -> reg_write stays 0, wb_count unchanged, fwd_data1 with rd_addr1=0 reads 0.
- Forwarding: queue {dest=3,data=0xA}, then {dest=3,data=0xB} under freeze, rf_data1=0x1, rd_addr1=3 -> fwd_data1=0xB. After release and both commits, fwd_data1 follows rf_data1 (=0xB).
- Backpressure: freeze=1 with 3 valid inputs (DEPTH=2) -> in_ready low after 2 accepts. dbg {dest=4,data=0x55} granted, rf[4]=0x55. After freeze drops, entries retire in order.
- Arbitration: queue non-empty, freeze=0, dbg_valid=1 -> dbg_ready=0 until the queue drains, then dbg_ready=1 for one cycle and the debug write commits.
- Reset mid-op: reset_n low with 2 entries queued -> reg_write=0 immediately, in_ready=0, no queued data written after release, wb_count=0.
